modmul_issue_queue: RTL and testbench
=====================================

Name: modmul_issue_queue

Overview:
Front-end and back-end wrapper around the 256-bit modular multiplier pipeline. It accepts operand pairs with a tag over a ready/valid request interface and buffers them. It issues at most one pair per cycle into the multiplier, which has no backpressure. It re-associates each in-order result with its tag and buffers results behind a ready/valid response interface. Credit-based issue control guarantees that a returning result never finds the response buffer full.

Parameters:
TAG_W, 4, request/response tag width
REQ_DEPTH, 4, request FIFO entries (power of two, >=2)
RSP_DEPTH, 32, response FIFO and tag FIFO entries (power of two); must be at least the multiplier latency for full throughput

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request offered
req_ready  out  1  request FIFO not full
req_x  in  256  operand X
req_y  in  256  operand Y
req_tag  in  TAG_W  request tag
mm_in_valid  out  1  issue strobe to multiplier in_valid
mm_xin  out  256  operand X to multiplier
mm_yin  out  256  operand Y to multiplier
mm_q  in  256  multiplier result Q
mm_out_valid  in  1  multiplier out_valid
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  consumer accepts response
rsp_q  out  256  result at response FIFO head
rsp_tag  out  TAG_W  tag at response FIFO head
inflight  out  clog2(RSP_DEPTH)+1  issued results not yet returned
err_orphan  out  1  sticky: result returned with tag FIFO empty

Behaviour:
- Reset (synchronous, active-high): all FIFOs empty; credit=RSP_DEPTH; inflight=0; mm_in_valid=0; mm_xin=mm_yin=0; rsp_valid=0; rsp_q=0; rsp_tag=0; err_orphan=0. Reset wins over every simultaneous event.
- Request FIFO:
  - req_ready = !req_full, driven from registered occupancy only; no combinational path from rsp_ready or mm_out_valid.
  - A push occurs when req_valid && req_ready.
  - When full, req_ready=0 even if a pop happens in the same cycle.
- Issue:
  - Fires in cycle t when the request FIFO is non-empty and credit>0.
  - The FIFO head pops, and {tag} is pushed into the tag FIFO.
  - In cycle t+1: mm_in_valid=1, with mm_xin/mm_yin = head operands. Outputs are registered.
  - mm_in_valid=0 in every non-issue cycle; mm_xin/mm_yin hold their last values.
- Latency: a request accepted in cycle t with an empty FIFO and available credit produces mm_in_valid in cycle t+2. Throughput is 1 issue per cycle.
- Credit accounting: credit = RSP_DEPTH - (inflight + rsp_count).
  - Decrements on issue.
  - Increments on rsp_valid && rsp_ready.
  - Issue and pop in the same cycle leave credit unchanged.
  - Credit never exceeds RSP_DEPTH and never goes below 0.
- Return path: the multiplier returns results in issue order.
  - On mm_out_valid with the tag FIFO non-empty: push {tag FIFO head, mm_q} into the response FIFO, pop the tag FIFO, and decrement inflight.
  - The response appears as rsp_valid in the cycle after mm_out_valid.
- Orphan result: on mm_out_valid with the tag FIFO empty, the result is dropped, err_orphan is set, and all counters are unchanged. err_orphan clears only on reset.
- Response FIFO:
  - Show-ahead: rsp_q and rsp_tag reflect the head whenever rsp_valid=1.
  - rsp_q and rsp_tag stay stable while rsp_valid && !rsp_ready.
  - A simultaneous push (mm_out_valid) and pop (rsp_ready) is supported in any state, including empty→push and full-1.
  - The credit scheme guarantees the response FIFO is never pushed while full.
- Pointers wrap modulo depth. Full/empty use an extra pointer bit.
- inflight: +1 on issue, -1 on a non-orphan return, unchanged when both happen in the same cycle.
- Reset mid-operation: all state is discarded. Results returned afterwards by the multiplier pipeline are orphans: they are dropped and flag err_orphan.

Test Plan:
- Reset: reset for 3 cycles with random inputs -> req_ready=1, rsp_valid=0, mm_in_valid=0, inflight=0, err_orphan=0.
- Single op: stub multiplier with latency 25 and Q=(X*Y) mod 2^256; accept x=3, y=5, tag=2 at cycle t -> mm_in_valid exactly at t+2; rsp_valid at t+28 with rsp_q=15, rsp_tag=2; inflight returns to 0.
- Streaming: 40 back-to-back requests, tags 0..15 wrapping, rsp_ready=1 -> 40 consecutive mm_in_valid cycles; 40 in-order responses with matching tags at 1 per cycle after fill.
- Backpressure: rsp_ready=0 while 50 requests are offered -> exactly 32 mm_in_valid pulses; req_ready drops after 4 more requests are buffered; raise rsp_ready -> all 50 responses delivered in order with none lost or duplicated.
- Orphan: mm_out_valid pulse with nothing issued -> rsp_valid stays 0, err_orphan=1 and stays set until reset.
- Mid-op reset: 10 requests in flight, assert reset one cycle -> FIFOs empty, inflight=0; the stub's 10 late results are dropped with err_orphan=1; a new request then completes normally.

Source files
------------

// File: rtl/modmul_issue_queue.sv
// modmul_issue_queue: credit-controlled request, tag and response buffering around a fixed-latency modular multiplier
module modmul_issue_queue #(
  parameter int TAG_W     = 4,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [255:0]                req_x,
  input  logic [255:0]                req_y,
  input  logic [TAG_W-1:0]            req_tag,
  output logic                        mm_in_valid,
  output logic [255:0]                mm_xin,
  output logic [255:0]                mm_yin,
  input  logic [255:0]                mm_q,
  input  logic                        mm_out_valid,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [255:0]                rsp_q,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic [$clog2(RSP_DEPTH):0]  inflight,
  output logic                        err_orphan
);
  localparam int RA = $clog2(REQ_DEPTH);
  localparam int SA = $clog2(RSP_DEPTH);
  localparam int RW = RA + 1;
  localparam int CW = SA + 1;
  logic [TAG_W+511:0] req_mem [REQ_DEPTH];
  logic [TAG_W-1:0]   tag_mem [RSP_DEPTH];
  logic [TAG_W+255:0] rsp_mem [RSP_DEPTH];
  logic [RA:0]        req_wr, req_rd;
  logic [SA:0]        tag_wr, tag_rd, rsp_wr, rsp_rd, credit;
  logic               req_empty, push, issue, tag_empty, ret, pop;
  logic [TAG_W+511:0] head;
  logic [TAG_W+255:0] rsp_head;
  assign req_empty = req_wr == req_rd;
  assign req_ready = req_wr != {~req_rd[RA], req_rd[RA-1:0]};
  assign push      = req_valid && req_ready;
  assign issue     = !req_empty && credit != '0;
  assign head      = req_mem[req_rd[RA-1:0]];
  assign tag_empty = tag_wr == tag_rd;
  assign ret       = mm_out_valid && !tag_empty;
  assign rsp_valid = rsp_wr != rsp_rd;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rd[SA-1:0]];
  // Gate the head so an empty FIFO presents zeros instead of stale storage
  assign rsp_q     = rsp_valid ? rsp_head[255:0] : '0;
  assign rsp_tag   = rsp_valid ? rsp_head[TAG_W+255:256] : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      req_wr      <= '0;
      req_rd      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      rsp_wr      <= '0;
      rsp_rd      <= '0;
      credit      <= CW'(RSP_DEPTH);
      inflight    <= '0;
      mm_in_valid <= 1'b0;
      mm_xin      <= '0;
      mm_yin      <= '0;
      err_orphan  <= 1'b0;
    end else begin
      if (push) begin
        req_mem[req_wr[RA-1:0]] <= {req_tag, req_x, req_y};
        req_wr <= req_wr + RW'(1);
      end
      mm_in_valid <= issue;
      if (issue) begin
        mm_xin <= head[511:256];
        mm_yin <= head[255:0];
        tag_mem[tag_wr[SA-1:0]] <= head[TAG_W+511:512];
        req_rd <= req_rd + RW'(1);
        tag_wr <= tag_wr + CW'(1);
      end
      // Credit covers both in-flight and buffered results, so this push always has room
      if (ret) begin
        rsp_mem[rsp_wr[SA-1:0]] <= {tag_mem[tag_rd[SA-1:0]], mm_q};
        tag_rd <= tag_rd + CW'(1);
        rsp_wr <= rsp_wr + CW'(1);
      end
      if (pop)
        rsp_rd <= rsp_rd + CW'(1);
      inflight <= inflight + CW'(issue) - CW'(ret);
      credit   <= credit - CW'(issue) + CW'(pop);
      if (mm_out_valid && tag_empty)
        err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_modmul_issue_queue.sv
// tb_modmul_issue_queue: directed checks with a latency-25 stub multiplier
module tb_modmul_issue_queue;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0, req_ready;
  logic [255:0] req_x = '0, req_y = '0;
  logic [3:0]   req_tag = '0;
  logic         mm_in_valid, mm_out_valid;
  logic [255:0] mm_xin, mm_yin, mm_q;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [255:0] rsp_q;
  logic [3:0]   rsp_tag;
  logic [5:0]   inflight;
  logic         err_orphan;
  logic         orph = 1'b0;
  int           checks = 0, failures = 0, cyc = 0;
  logic [255:0] pq [25];
  logic [24:0]  pv = '0;
  logic [259:0] exp_q[$], got_q[$];
  int           iss_cyc[$], rsp_cyc[$];

  modmul_issue_queue dut (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .mm_in_valid(mm_in_valid),
    .mm_xin(mm_xin), .mm_yin(mm_yin), .mm_q(mm_q), .mm_out_valid(mm_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_tag(rsp_tag),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub multiplier: 25-cycle pipeline, ignores reset like the real datapath
  always @(posedge clk) begin
    pv <= {pv[23:0], mm_in_valid === 1'b1};
    pq[0] <= mm_xin * mm_yin;
    for (int i = 1; i < 25; i++) pq[i] <= pq[i-1];
  end
  assign mm_out_valid = pv[24] | orph;
  assign mm_q = pq[24];

  always @(negedge clk) begin
    if (!reset && mm_in_valid === 1'b1) iss_cyc.push_back(cyc);
    if (!reset && rsp_valid === 1'b1 && rsp_ready) begin
      got_q.push_back({rsp_tag, rsp_q});
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [255:0] x, input logic [255:0] y, input logic [3:0] t);
    int n = 0;
    req_valid = 1'b1; req_x = x; req_y = y; req_tag = t;
    while (!req_ready && n < 200) begin tick(); n++; end
    chk("send_ready", req_ready, 1);
    tick();
    exp_q.push_back({t, x * y});
  endtask

  task automatic wait_rsp(input int n, input int bound);
    int k = 0;
    while (got_q.size() < n && k < bound) begin tick(); k++; end
    chk("rsp_count", got_q.size(), n);
  endtask

  task automatic clear_logs();
    exp_q.delete(); got_q.delete(); iss_cyc.delete(); rsp_cyc.delete();
  endtask

  initial begin
    int n, start;
    logic ok;
    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'($urandom); req_x = {8{$urandom}}; req_y = {8{$urandom}};
      req_tag = 4'($urandom); rsp_ready = 1'($urandom); orph = 1'($urandom);
      tick();
    end
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mm_in_valid", mm_in_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_rsp_q", rsp_q, 0);
    chk("rst_mm_xin", mm_xin, 0);
    req_valid = 0; rsp_ready = 0; orph = 0; reset = 0;
    tick();
    // single op: latency 2 to issue, 28 to response
    req_valid = 1; req_x = 3; req_y = 5; req_tag = 2;
    tick();
    req_valid = 0;
    chk("single_t1_mm_in_valid", mm_in_valid, 0);
    tick();
    chk("single_t2_mm_in_valid", mm_in_valid, 1);
    chk("single_mm_xin", mm_xin, 3);
    chk("single_mm_yin", mm_yin, 5);
    chk("single_inflight1", inflight, 1);
    tick();
    chk("single_t3_mm_in_valid", mm_in_valid, 0);
    chk("single_xin_hold", mm_xin, 3);
    repeat (24) tick();
    chk("single_t27_rsp_valid", rsp_valid, 0);
    tick();
    chk("single_t28_rsp_valid", rsp_valid, 1);
    chk("single_rsp_q", rsp_q, 15);
    chk("single_rsp_tag", rsp_tag, 2);
    chk("single_inflight0", inflight, 0);
    tick();
    chk("single_rsp_q_stable", rsp_q, 15);
    rsp_ready = 1;
    tick();
    chk("single_drained", rsp_valid, 0);
    // streaming 40 back-to-back
    clear_logs();
    for (int i = 0; i < 40; i++) send(256'(i + 7), 256'(3 * i + 1) << 200, 4'(i));
    req_valid = 0;
    wait_rsp(40, 200);
    chk("stream_issues", iss_cyc.size(), 40);
    chk("stream_issue_span", iss_cyc[39] - iss_cyc[0], 39);
    chk("stream_rsp_span", rsp_cyc[39] - rsp_cyc[0], 39);
    for (int i = 0; i < 40; i++) chk($sformatf("stream_rsp%0d", i), got_q[i], exp_q[i]);
    chk("stream_inflight", inflight, 0);
    // backpressure: 32 credits plus 4 buffered requests
    clear_logs();
    rsp_ready = 0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      req_valid = 1; req_x = 256'(n + 100); req_y = 256'(n + 2); req_tag = 4'(n);
      ok = req_ready;
      tick();
      if (ok) begin exp_q.push_back({4'(n), 256'(n + 100) * 256'(n + 2)}); n++; end
    end
    chk("bp_accepted", n, 36);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_issues", iss_cyc.size(), 32);
    chk("bp_inflight", inflight, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_none_popped", got_q.size(), 0);
    rsp_ready = 1;
    start = 0;
    while (n < 50 && start < 500) begin
      req_valid = 1; req_x = 256'(n + 100); req_y = 256'(n + 2); req_tag = 4'(n);
      ok = req_ready;
      tick();
      if (ok) begin exp_q.push_back({4'(n), 256'(n + 100) * 256'(n + 2)}); n++; end
      start++;
    end
    req_valid = 0;
    wait_rsp(50, 500);
    repeat (40) tick();
    chk("bp_no_dup", got_q.size(), 50);
    for (int i = 0; i < 50; i++) chk($sformatf("bp_rsp%0d", i), got_q[i], exp_q[i]);
    chk("bp_final_inflight", inflight, 0);
    chk("bp_final_rsp_valid", rsp_valid, 0);
    // orphan result
    clear_logs();
    orph = 1;
    tick();
    orph = 0;
    chk("orph_rsp_valid", rsp_valid, 0);
    chk("orph_err", err_orphan, 1);
    chk("orph_inflight", inflight, 0);
    repeat (5) tick();
    chk("orph_sticky", err_orphan, 1);
    chk("orph_none", got_q.size(), 0);
    // mid-operation reset
    for (int i = 0; i < 10; i++) send(256'(i + 1), 256'(i + 2), 4'(i));
    req_valid = 0;
    n = 0;
    while (iss_cyc.size() < 10 && n < 50) begin tick(); n++; end
    chk("mid_issues", iss_cyc.size(), 10);
    chk("mid_inflight10", inflight, 10);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_err", err_orphan, 0);
    clear_logs();
    repeat (35) tick();
    chk("mid_late_dropped", got_q.size(), 0);
    chk("mid_late_err", err_orphan, 1);
    chk("mid_late_inflight", inflight, 0);
    send(256'd9, 256'd11, 4'd7);
    req_valid = 0;
    wait_rsp(1, 100);
    chk("mid_new_rsp", got_q[0], {4'd7, 256'd99});
    tick();
    chk("mid_new_inflight", inflight, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
